// File: rtl/edge_event_scheduler.sv
// Sticky falling-edge capture with per-bit serviced clearing.
// Pending flags are arbitrated round-robin and delivered one index at a time over valid/ready.
module edge_event_scheduler #(
  parameter int DATAWIDTH = 32,
  parameter int IDXW      = $clog2(DATAWIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATAWIDTH-1:0] data_i,
  input  logic [DATAWIDTH-1:0] mask_i,
  output logic                 evt_valid_o,
  output logic [IDXW-1:0]      evt_idx_o,
  input  logic                 evt_ready_i,
  output logic [DATAWIDTH-1:0] pending_o,
  output logic [DATAWIDTH-1:0] overflow_o,
  input  logic                 ovf_clr_i
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t               state_q;
  logic                 valid_q;
  logic [IDXW-1:0]      idx_q;
  logic [IDXW-1:0]      rr_q;
  logic [IDXW-1:0]      rr_d;
  logic [DATAWIDTH-1:0] data_prv_q;
  logic [DATAWIDTH-1:0] pending_q;
  logic [DATAWIDTH-1:0] pending_d;
  logic [DATAWIDTH-1:0] overflow_q;
  logic [DATAWIDTH-1:0] overflow_d;

  logic [DATAWIDTH-1:0] fall_vec;
  logic [DATAWIDTH-1:0] clr_vec;
  logic [DATAWIDTH-1:0] eligible_vec;
  logic                 accept;
  logic                 pick_found;
  logic [IDXW-1:0]      pick_idx;
  logic [IDXW:0]        pick_sum;

  assign accept       = (state_q == OFFER) && evt_ready_i;
  assign fall_vec     = data_prv_q & ~data_i & mask_i;
  assign eligible_vec = pending_q & mask_i;

  genvar gi;
  generate
    for (gi = 0; gi < DATAWIDTH; gi++) begin : g_clr
      assign clr_vec[gi] = accept && (idx_q == IDXW'(gi));
    end
  endgenerate

  // A fresh edge on the bit being accepted re-arms it and is not an overflow.
  assign pending_d  = (pending_q & ~clr_vec) | fall_vec;
  assign overflow_d = (ovf_clr_i ? '0 : overflow_q) | (fall_vec & pending_q & ~clr_vec);

  assign rr_d = (idx_q == IDXW'(DATAWIDTH - 1)) ? '0 : idx_q + 1'b1;

  // Scan offsets high to low so the smallest offset from the pointer wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_sum   = '0;
    for (int i = DATAWIDTH - 1; i >= 0; i--) begin
      pick_sum = {1'b0, rr_q} + (IDXW+1)'(i);
      if (pick_sum >= (IDXW+1)'(DATAWIDTH)) begin
        pick_sum = pick_sum - (IDXW+1)'(DATAWIDTH);
      end
      if (eligible_vec[pick_sum[IDXW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = pick_sum[IDXW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      rr_q       <= '0;
      data_prv_q <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      data_prv_q <= data_i;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            idx_q   <= pick_idx;
            valid_q <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          // The offer is held regardless of mask changes until accepted.
          if (evt_ready_i) begin
            rr_q    <= rr_d;
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_idx_o   = idx_q;
  assign pending_o   = pending_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed bench for edge_event_scheduler: a per-cycle reference model plus hand-computed checks.
module tb_edge_event_scheduler;
  localparam int DW = 32;
  localparam int IW = $clog2(DW);

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_i;
  logic [DW-1:0] mask_i;
  logic          evt_valid_o;
  logic [IW-1:0] evt_idx_o;
  logic          evt_ready_i;
  logic [DW-1:0] pending_o;
  logic [DW-1:0] overflow_o;
  logic          ovf_clr_i;

  edge_event_scheduler #(.DATAWIDTH(DW)) dut (
    .clk(clk), .reset(reset), .data_i(data_i), .mask_i(mask_i),
    .evt_valid_o(evt_valid_o), .evt_idx_o(evt_idx_o), .evt_ready_i(evt_ready_i),
    .pending_o(pending_o), .overflow_o(overflow_o), .ovf_clr_i(ovf_clr_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int dq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_seq(input string nm, input int n, input int a, input int b, input int c);
    int e[3];
    e = '{a, b, c};
    chk({nm, "_count"}, dq.size(), n);
    for (int i = 0; i < n && i < dq.size(); i++) chk($sformatf("%s_%0d", nm, i), dq[i], e[i]);
    $display("order %s: %p", nm, dq);
  endtask

  // Reference model: event flags, sticky overflows, one outstanding offer, rotating start point.
  bit [DW-1:0] m_prv, m_pend, m_ovf;
  bit          m_valid;
  int          m_idx, m_rr;

  always @(posedge clk) begin
    if (reset) begin
      m_prv = '0; m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_idx = 0; m_rr = 0;
    end else begin
      bit [DW-1:0] np, no;
      bit acc, f, c;
      acc = m_valid && evt_ready_i;
      for (int k = 0; k < DW; k++) begin
        f = m_prv[k] && !data_i[k] && mask_i[k];
        c = acc && (m_idx == k);
        np[k] = f || (m_pend[k] && !c);
        no[k] = (f && m_pend[k] && !c) || (m_ovf[k] && !ovf_clr_i);
      end
      if (m_valid) begin
        if (acc) begin
          m_valid = 1'b0;
          m_rr = (m_idx + 1) % DW;
        end
      end else begin
        for (int off = 0; off < DW; off++) begin
          if (m_pend[(m_rr + off) % DW] && mask_i[(m_rr + off) % DW]) begin
            m_idx = (m_rr + off) % DW;
            m_valid = 1'b1;
            break;
          end
        end
      end
      m_prv = data_i; m_pend = np; m_ovf = no;
    end
  end

  always @(posedge clk)
    if (!reset && evt_valid_o && evt_ready_i) dq.push_back(int'(evt_idx_o));

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid", evt_valid_o, m_valid);
      if (m_valid) chk("model_idx", evt_idx_o, m_idx);
      chk("model_pending", pending_o, m_pend);
      chk("model_overflow", overflow_o, m_ovf);
    end
  end

  initial begin
    reset = 1'b1; data_i = '1; mask_i = '1; evt_ready_i = 1'b0; ovf_clr_i = 1'b0;
    tick(2);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_pending", pending_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_valid", evt_valid_o, 0);
    chk("rst_idx", evt_idx_o, 0);
    $display("reset: pending=0x%0h valid=%0d", pending_o, evt_valid_o);

    // Single edge on bit 5
    tick(2);
    data_i = ~(32'h1 << 5); evt_ready_i = 1'b1;
    tick(1);
    chk("single_pending", pending_o, 32'h20);
    chk("single_valid_early", evt_valid_o, 0);
    tick(1);
    chk("single_valid", evt_valid_o, 1);
    chk("single_idx", evt_idx_o, 5);
    tick(1);
    chk("single_pending_clr", pending_o, 0);
    chk("single_valid_clr", evt_valid_o, 0);
    $display("single edge: idx 5 delivered");
    data_i = '1; evt_ready_i = 1'b0;

    // Round-robin from pointer 0
    reset = 1'b1; tick(1); reset = 1'b0; tick(2);
    dq.delete();
    evt_ready_i = 1'b1;
    data_i = ~((32'h1 << 3) | (32'h1 << 10) | (32'h1 << 31));
    tick(1); data_i = '1; tick(8);
    chk_seq("rr_first", 3, 3, 10, 31);

    dq.delete();
    data_i = ~((32'h1 << 3) | (32'h1 << 31));
    tick(1); data_i = '1; tick(6);
    chk_seq("rr_wrap", 2, 3, 31, 0);

    dq.delete();
    data_i = ~(32'h1 << 10);
    tick(1); data_i = '1; tick(3);
    data_i = ~((32'h1 << 3) | (32'h1 << 31));
    tick(1); data_i = '1; tick(6);
    chk_seq("rr_ptr11", 3, 10, 31, 3);

    // Backpressure on bit 7, bit 2 queued behind it
    evt_ready_i = 1'b0;
    data_i = ~(32'h1 << 7);
    tick(2);
    data_i = ~((32'h1 << 7) | (32'h1 << 2));
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk($sformatf("bp_valid_%0d", i), evt_valid_o, 1);
      chk($sformatf("bp_idx_%0d", i), evt_idx_o, 7);
    end
    evt_ready_i = 1'b1;
    tick(1);
    chk("bp_after_acc_valid", evt_valid_o, 0);
    chk("bp_after_acc_pending", pending_o, 32'h4);
    tick(1);
    chk("bp_next_valid", evt_valid_o, 1);
    chk("bp_next_idx", evt_idx_o, 2);
    $display("backpressure: 7 held 10 cycles then 2 offered");
    tick(1);
    data_i = '1; evt_ready_i = 1'b0;
    tick(1);

    // Overflow on bit 4 while bit 1 is being offered
    data_i = ~32'h2;
    tick(2);
    chk("ovf_offer_idx", evt_idx_o, 1);
    data_i = ~32'h12; tick(1);
    chk("ovf_pending", pending_o, 32'h12);
    data_i = ~32'h2; tick(1);
    data_i = ~32'h12; tick(1);
    chk("ovf_set", overflow_o, 32'h10);
    ovf_clr_i = 1'b1; tick(1); ovf_clr_i = 1'b0;
    chk("ovf_clr", overflow_o, 0);
    data_i = ~32'h2; evt_ready_i = 1'b1;
    tick(2);
    chk("simul_offer_idx", evt_idx_o, 4);
    data_i = ~32'h12;
    tick(1);
    chk("simul_pend4", pending_o[4], 1);
    chk("simul_no_ovf", overflow_o, 0);
    chk("simul_valid", evt_valid_o, 0);
    tick(1);
    chk("simul_reoffer", evt_idx_o, 4);
    $display("overflow: set 0x10, cleared; same-cycle re-arm keeps bit 4 pending");
    tick(1);
    data_i = '1;
    tick(1);

    // Masking
    mask_i = ~(32'h1 << 9); data_i = ~(32'h1 << 9);
    tick(3);
    chk("mask_no_pending", pending_o, 0);
    chk("mask_no_valid", evt_valid_o, 0);
    data_i = '1; tick(1);
    mask_i = '1; data_i = ~(32'h1 << 9); tick(1);
    chk("mask_pending", pending_o, 32'h200);
    mask_i = ~(32'h1 << 9); tick(3);
    chk("mask_held_valid", evt_valid_o, 0);
    chk("mask_held_pending", pending_o, 32'h200);
    mask_i = '1; tick(1);
    chk("mask_reen_valid", evt_valid_o, 1);
    chk("mask_reen_idx", evt_idx_o, 9);
    mask_i = ~(32'h1 << 9); evt_ready_i = 1'b0; tick(2);
    chk("mask_offer_valid", evt_valid_o, 1);
    chk("mask_offer_idx", evt_idx_o, 9);
    evt_ready_i = 1'b1; tick(1);
    chk("mask_offer_done", evt_valid_o, 0);
    chk("mask_offer_pend", pending_o, 0);
    $display("masking: bit 9 gated, held, then offered and completed");
    mask_i = '1; evt_ready_i = 1'b0; data_i = '1; tick(1);

    // Reset in the middle of an offer
    data_i = ~32'h81; tick(2);
    chk("mid_pending", pending_o, 32'h81);
    chk("mid_valid", evt_valid_o, 1);
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("mid_rst_valid", evt_valid_o, 0);
    chk("mid_rst_pending", pending_o, 0);
    chk("mid_rst_idx", evt_idx_o, 0);
    tick(3);
    chk("mid_quiet_valid", evt_valid_o, 0);
    chk("mid_quiet_pending", pending_o, 0);
    data_i = '1; tick(1);
    data_i = ~32'h1; tick(2);
    chk("mid_fresh_valid", evt_valid_o, 1);
    chk("mid_fresh_idx", evt_idx_o, 0);
    $display("mid reset: offer discarded, fresh edge on bit 0 offered");
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
